// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage feeding simple_cpu.
// Field helpers describe the CPU word layout so stimulus and tools agree on encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int INSTR_WIDTH_DEF = 20;
    localparam int ADDR_BITS_DEF   = 5;
    localparam logic [19:0] HALT_WORD_DEF = 20'hFFFFF;

    // simple_cpu word layout: opcode[19:18] x1[17:16] x2[15:14] x3[13:12] imm[11:4] func[3:0]
    localparam logic [1:0] OPC_ADD_SUB = 2'b01;
    localparam logic [1:0] OPC_LOAD_R  = 2'b10;
    localparam logic [1:0] OPC_STORE_R = 2'b11;
    localparam logic [3:0] FUNC_ADD    = 4'h0;
    localparam logic [3:0] FUNC_SUB    = 4'h1;

    function automatic logic [19:0] pack_instr(
        input logic [1:0] opc,
        input logic [1:0] x1,
        input logic [1:0] x2,
        input logic [1:0] x3,
        input logic [7:0] imm,
        input logic [3:0] func
    );
        return {opc, x1, x2, x3, imm, func};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load and CPU-facing handshake bundle of the fetch stage.
// The master side loads the store, starts runs and acknowledges words; the slave is the fetch unit.
interface instr_fetch_unit_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
);
    logic                   prog_we;
    logic [ADDR_BITS-1:0]   prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   start;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [ADDR_BITS-1:0]   pc;
    logic                   busy;
    logic                   done;

    modport master (
        output prog_we, prog_addr, prog_data, start, instr_ready,
        input  instruction, instr_valid, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, instr_ready,
        output instruction, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_rom.sv
// Instruction store: synchronous write, registered read, no reset on the array or read register.
// A write and a read of the same address on one edge return the old word; callers read one edge later.
module instr_rom #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [ADDR_BITS-1:0]   i_waddr,
    input  logic [INSTR_WIDTH-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0]   i_raddr,
    output logic [INSTR_WIDTH-1:0] o_rdata
);
    logic [INSTR_WIDTH-1:0] r_mem [2**ADDR_BITS];
    logic [INSTR_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage ahead of simple_cpu: sequences store words onto the CPU under valid/ready,
// stopping on the halt sentinel or at the last store address.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start; store writable
//   ST_FETCH | store read in flight (read edge, then decode edge)
//   ST_ISSUE | word presented, held until instr_valid && instr_ready
//   ST_HALT  | run finished; store writable, start re-runs from pc 0
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                     ADDR_BITS   = ADDR_BITS_DEF,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = HALT_WORD_DEF
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.slave bus
);
    localparam logic [ADDR_BITS-1:0] PC_LAST = '1;

    fetch_state_t           r_state;
    logic [ADDR_BITS-1:0]   r_pc;
    logic [INSTR_WIDTH-1:0] r_instruction;
    logic                   r_instr_valid;
    logic                   r_rd_done;

    logic                   w_prog_en;
    logic                   w_handshake;
    logic [INSTR_WIDTH-1:0] w_rd_data;

    assign w_prog_en   = bus.prog_we && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_handshake = r_instr_valid && bus.instr_ready;

    instr_rom #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_BITS   (ADDR_BITS)
    ) u_rom (
        .clk     (clk),
        .i_we    (w_prog_en),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_rd_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (bus.start) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= '0;
                        r_rd_done <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // First FETCH edge captures the store read at r_pc (sees a same-edge-as-start write);
                    // the second edge decodes it.
                    if (!r_rd_done) begin
                        r_rd_done <= 1'b1;
                    end else begin
                        r_rd_done <= 1'b0;
                        if (w_rd_data == HALT_WORD) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_instruction <= w_rd_data;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_handshake) begin
                        r_instruction <= '0;
                        r_instr_valid <= 1'b0;
                        if (r_pc == PC_LAST) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.instruction = r_instruction;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign bus.busy        = (r_state == ST_FETCH) || (r_state == ST_ISSUE);
    assign bus.done        = (r_state == ST_HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: load/run, back-pressure, store end, reset mid-run,
// writes while busy and write-with-start, all with hand-computed expected words.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.INSTR_WIDTH(20), .ADDR_BITS(5)) bus ();

    instr_fetch_unit #(
        .INSTR_WIDTH (20),
        .ADDR_BITS   (5),
        .HALT_WORD   (20'hFFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec      = 0;
    int n_miss     = 0;
    int n_halt_iss = 0;

    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1 && bus.instruction == 20'hFFFFF) n_halt_iss++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [19:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.instr_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 2);
    endtask

    // ready raised one cycle after valid is seen; handshake on the following edge
    task automatic handshake(input string tag);
        tick();
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk({tag, "_vclr"}, bus.instr_valid, 0);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, bus.done, 1);
    endtask

    task automatic run_expect(input string tag, input logic [19:0] w0, input logic [19:0] w1,
                              input logic [19:0] w2);
        logic [19:0] exp_w [3];
        exp_w[0] = w0;
        exp_w[1] = w1;
        exp_w[2] = w2;
        for (int i = 0; i < 3; i++) begin
            wait_valid(tag);
            chk({tag, "_instr"}, bus.instruction, exp_w[i]);
            chk({tag, "_pc"}, bus.pc, i);
            handshake(tag);
        end
        wait_done(tag);
        chk({tag, "_hpc"}, bus.pc, 3);
        chk({tag, "_hbusy"}, bus.busy, 0);
        chk({tag, "_hinstr"}, bus.instruction, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.instr_valid, 0);
        chk({tag, "_instr"}, bus.instruction, 0);
        chk({tag, "_pc"}, bus.pc, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    logic [19:0] w_ld;
    logic [19:0] w_st;
    logic [19:0] w_sub;
    int          n_iss;
    int          bad_pc;
    int          last_pc;
    int          cyc;

    initial begin
        bus.prog_we     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;
        bus.start       = 1'b0;
        bus.instr_ready = 1'b0;

        w_ld  = pack_instr(OPC_LOAD_R,  2'b11, 2'b10, 2'b00, 8'h0F, FUNC_ADD);  // 20'hB80F0
        w_st  = pack_instr(OPC_STORE_R, 2'b01, 2'b10, 2'b00, 8'h0F, FUNC_ADD);  // 20'hD80F0
        w_sub = pack_instr(OPC_ADD_SUB, 2'b11, 2'b00, 2'b10, 8'h00, FUNC_SUB);  // 20'h72001

        tick();
        tick();
        chk_reset_outputs("rst0");
        rst = 1'b1;
        tick();

        // load and run, with start/issue latency checks
        write_word(5'd0, 20'h47000);
        write_word(5'd1, 20'h53000);
        write_word(5'd2, w_sub);
        write_word(5'd3, 20'hFFFFF);
        pulse_start();
        chk("start_busy", bus.busy, 1);
        chk("start_v0", bus.instr_valid, 0);
        run_expect("run1", 20'h47000, 20'h53000, 20'h72001);

        // back-pressure, with a store write attempted during ISSUE of addr 0
        pulse_start();
        wait_valid("bp");
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'd1;
        bus.prog_data = w_ld;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.prog_we = 1'b0;
            chk("bp_instr", bus.instruction, 20'h47000);
            chk("bp_valid", bus.instr_valid, 1);
            chk("bp_pc", bus.pc, 0);
        end
        handshake("bp");
        wait_valid("bp1");
        chk("wbusy_instr", bus.instruction, 20'h53000);
        chk("wbusy_pc", bus.pc, 1);
        handshake("bp1");
        wait_valid("bp2");
        chk("bp2_instr", bus.instruction, 20'h72001);
        handshake("bp2");
        wait_done("bp");

        // write and start on the same edge in HALT
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'd0;
        bus.prog_data = 20'h12345;
        bus.start     = 1'b1;
        tick();
        bus.prog_we   = 1'b0;
        bus.start     = 1'b0;
        wait_valid("wst");
        chk("wst_instr", bus.instruction, 20'h12345);
        chk("wst_pc", bus.pc, 0);
        handshake("wst");
        wait_valid("wst1");
        handshake("wst1");
        wait_valid("wst2");
        chk("mid_pc", bus.pc, 2);

        // reset during ISSUE at pc 2
        rst = 1'b0;
        tick();
        chk_reset_outputs("rstmid");
        rst = 1'b1;
        tick();
        chk("rstmid_idle", bus.busy, 0);
        pulse_start();
        run_expect("rerun", 20'h12345, 20'h53000, 20'h72001);

        // end of store: every location a non-halt word, ready held high
        for (int a = 0; a < 32; a++) write_word(5'(a), w_st);
        bus.instr_ready = 1'b1;
        pulse_start();
        n_iss   = 0;
        bad_pc  = 0;
        last_pc = -1;
        cyc     = 0;
        while (!bus.done && cyc < 300) begin
            if (bus.instr_valid) begin
                if (bus.pc != 5'(n_iss) || bus.instruction != 20'hD80F0) bad_pc++;
                last_pc = int'(bus.pc);
                n_iss++;
            end
            tick();
            cyc++;
        end
        bus.instr_ready = 1'b0;
        chk("eos_issues", n_iss, 32);
        chk("eos_lastpc", last_pc, 31);
        chk("eos_order", bad_pc, 0);
        chk("eos_done", bus.done, 1);
        tick();
        tick();
        chk("eos_nowrap", bus.pc, 31);
        chk("eos_still", bus.done, 1);

        chk("halt_never_valid", n_halt_iss, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
